// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 store path: access sizes, error codes and
// the store-unit state encoding.
package msrv32_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } store_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } store_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/msrv32_store_align.sv
// Combinational lane steering for stores: replicates the source data across
// byte lanes, builds the byte-enable mask and flags misaligned/illegal sizes.
module msrv32_store_align
    import msrv32_pkg::*;
(
    input  store_size_e size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    output logic [31:0] data,
    output logic [3:0]  mask,
    output logic        aligned
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        data    = rs2;
        mask    = 4'b0000;
        aligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                data    = {4{rs2[7:0]}};
                mask    = 4'b0001 << addr_lo;
                aligned = 1'b1;
            end
            SIZE_HALF: begin
                data    = {2{rs2[15:0]}};
                mask    = addr_lo[1] ? 4'b1100 : 4'b0011;
                aligned = ~addr_lo[0];
            end
            SIZE_WORD: begin
                data    = rs2;
                mask    = 4'b1111;
                aligned = (addr_lo == 2'b00);
            end
            default: begin
                aligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/msrv32_store_unit.sv
// Store unit: accepts one store at a time, holds the bus write request until
// the bus responds or the response window expires, and reports done/error.
module msrv32_store_unit
    import msrv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        store_req_in,
    input  logic [1:0]  store_size_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic        ahb_resp_in,
    output logic [31:0] ms_riscv32_mp_dmaddr_out,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
    output logic        ms_riscv32_mp_dmwr_req_out,
    output logic        store_busy_out,
    output logic        store_done_out,
    output logic [1:0]  store_err_out
);

    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    store_state_e state, state_next;
    logic [7:0]   count, count_next;
    logic [31:0]  addr_next, data_next;
    logic [3:0]   mask_next;
    logic         req_next, done_next;
    logic [1:0]   err_next;

    logic [31:0]  align_data;
    logic [3:0]   align_mask;
    logic         align_ok;

    msrv32_store_align u_align (
        .size    (store_size_e'(store_size_in)),
        .addr_lo (iadder_in[1:0]),
        .rs2     (rs2_in),
        .data    (align_data),
        .mask    (align_mask),
        .aligned (align_ok)
    );

    assign store_busy_out = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        count_next = count;
        addr_next  = ms_riscv32_mp_dmaddr_out;
        data_next  = ms_riscv32_mp_dmdata_out;
        mask_next  = ms_riscv32_mp_dmwr_mask_out;
        req_next   = ms_riscv32_mp_dmwr_req_out;
        done_next  = 1'b0;
        err_next   = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (store_req_in) begin
                    if (align_ok) begin
                        state_next = ST_BUSY;
                        count_next = 8'd0;
                        addr_next  = {iadder_in[31:2], 2'b00};
                        data_next  = align_data;
                        mask_next  = align_mask;
                        req_next   = 1'b1;
                    end else begin
                        err_next = ERR_MISALIGN;
                    end
                end
            end
            ST_BUSY: begin
                // A response arriving on the last window cycle still counts as success.
                if (ahb_resp_in) begin
                    state_next = ST_IDLE;
                    count_next = 8'd0;
                    mask_next  = 4'b0000;
                    req_next   = 1'b0;
                    done_next  = 1'b1;
                end else if (count == COUNT_LAST) begin
                    state_next = ST_IDLE;
                    count_next = 8'd0;
                    mask_next  = 4'b0000;
                    req_next   = 1'b0;
                    err_next   = ERR_TIMEOUT;
                end else begin
                    count_next = count + 8'd1;
                end
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state                       <= ST_IDLE;
            count                       <= 8'd0;
            ms_riscv32_mp_dmaddr_out    <= 32'd0;
            ms_riscv32_mp_dmdata_out    <= 32'd0;
            ms_riscv32_mp_dmwr_mask_out <= 4'b0000;
            ms_riscv32_mp_dmwr_req_out  <= 1'b0;
            store_done_out              <= 1'b0;
            store_err_out               <= ERR_NONE;
        end else begin
            state                       <= state_next;
            count                       <= count_next;
            ms_riscv32_mp_dmaddr_out    <= addr_next;
            ms_riscv32_mp_dmdata_out    <= data_next;
            ms_riscv32_mp_dmwr_mask_out <= mask_next;
            ms_riscv32_mp_dmwr_req_out  <= req_next;
            store_done_out              <= done_next;
            store_err_out               <= err_next;
        end
    end

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Randomized self-checking bench for msrv32_store_unit against a byte-lane
// reference model.
module tb_msrv32_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] iadder = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        resp = 1'b0;
    logic [31:0] dmaddr, dmdata;
    logic [3:0]  dmmask;
    logic        dmreq, busy, done;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    msrv32_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .ms_riscv32_mp_clk_in        (clk),
        .ms_riscv32_mp_rst_in        (rst),
        .store_req_in                (req),
        .store_size_in               (size),
        .iadder_in                   (iadder),
        .rs2_in                      (rs2),
        .ahb_resp_in                 (resp),
        .ms_riscv32_mp_dmaddr_out    (dmaddr),
        .ms_riscv32_mp_dmdata_out    (dmdata),
        .ms_riscv32_mp_dmwr_mask_out (dmmask),
        .ms_riscv32_mp_dmwr_req_out  (dmreq),
        .store_busy_out              (busy),
        .store_done_out              (done),
        .store_err_out               (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: an access of n bytes is legal when the address is a multiple
    // of n; the value occupies lanes [addr%4 .. addr%4+n-1] and repeats to fill 32 bits.
    function automatic void ref_store(input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] d, output logic legal,
                                      output logic [31:0] data, output logic [3:0] mask);
        int nbytes;
        int lane;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
        lane   = int'(a % 4);
        legal  = (nbytes != 0) && ((a % nbytes) == 0);
        if (nbytes == 4)      data = d;
        else if (nbytes == 2) data = {16'd0, d[15:0]} * 32'h0001_0001;
        else                  data = {24'd0, d[7:0]} * 32'h0101_0101;
        mask = legal ? 4'(((1 << nbytes) - 1) << lane) : 4'b0000;
    endfunction

    // Checks {busy, req, done, err, mask} as one packed control word.
    task automatic check_ctl(input string tag, input logic b, input logic r,
                             input logic dn, input logic [1:0] e, input logic [3:0] m);
        logic [8:0] got, exp;
        got = {busy, dmreq, done, err, dmmask};
        exp = {b, r, dn, e, m};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s ctl {busy,req,done,err,mask}: got %b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                     tag, got[8], got[7], got[6], got[5:4], got[3:0],
                     exp[8], exp[7], exp[6], exp[5:4], exp[3:0]);
        end
    endtask

    // Presents one store in the current (IDLE) cycle. resp_at = BUSY cycle in
    // which the bus responds (> TO means never). Returns in the cycle after
    // completion with req deasserted, so a following call is back-to-back.
    task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d, input int resp_at);
        logic        legal;
        logic [31:0] exp_data;
        logic [3:0]  exp_mask;
        ref_store(sz, a, d, legal, exp_data, exp_mask);
        req = 1'b1; size = sz; iadder = a; rs2 = d; resp = 1'b0;
        tick();
        if (!legal) begin
            req = 1'b0;
            check_ctl({tag, ":reject"}, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000);
            tick();
            check_ctl({tag, ":after_reject"}, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000);
            return;
        end
        check_ctl({tag, ":accept"}, 1'b1, 1'b1, 1'b0, 2'b00, exp_mask);
        for (int k = 1; k <= TO; k++) begin
            req    = 1'($urandom_range(0, 1));
            size   = 2'($urandom_range(0, 3));
            iadder = $urandom;
            rs2    = $urandom;
            resp   = (k == resp_at);
            checks++;
            if (dmaddr !== (a & 32'hFFFF_FFFC) || dmdata !== exp_data) begin
                errors++;
                $display("FAIL %s:busy%0d addr/data: got %h/%h want %h/%h", tag, k,
                         dmaddr, dmdata, a & 32'hFFFF_FFFC, exp_data);
            end
            tick();
            if (k == resp_at) begin
                check_ctl({tag, ":done"}, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000);
                break;
            end else if (k == TO) begin
                check_ctl({tag, ":timeout"}, 1'b0, 1'b0, 1'b0, 2'b10, 4'b0000);
            end else begin
                check_ctl({tag, ":hold"}, 1'b1, 1'b1, 1'b0, 2'b00, exp_mask);
            end
        end
        req = 1'b0; resp = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        check_ctl("reset_async", 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000);
        req = 1'b1; size = 2'b10; iadder = 32'h0000_0100; rs2 = 32'h1;
        tick();
        tick();
        check_ctl("reset_held", 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000);
        checks++;
        if (dmaddr !== 32'd0 || dmdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h want 0/0", dmaddr, dmdata);
        end
        req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        do_store("byte_1003", 2'b00, 32'h0000_1003, 32'hAABB_CCDD, 3);
        tick();
        do_store("half_2002", 2'b01, 32'h0000_2002, 32'h1234_5678, 2);
        do_store("half_b2b", 2'b01, 32'h0000_2000, 32'h1234_5678, 1);
        do_store("word_b2b", 2'b10, 32'h0000_2004, 32'hCAFE_F00D, 1);
        tick();
        do_store("word_3001", 2'b10, 32'h0000_3001, 32'h1111_1111, 1);
        do_store("size11_3000", 2'b11, 32'h0000_3000, 32'h2222_2222, 1);
        do_store("half_odd", 2'b01, 32'h0000_3003, 32'h3333_3333, 1);
        do_store("word_timeout", 2'b10, 32'h0000_4000, 32'h4444_4444, TO + 1);
        do_store("word_resp_last", 2'b10, 32'h0000_4000, 32'h5555_5555, TO);
    endtask

    task automatic test_resp_in_idle();
        resp = 1'b1;
        req  = 1'b0;
        repeat (3) begin
            tick();
            check_ctl("resp_idle", 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000);
        end
        resp = 1'b0;
    endtask

    task automatic test_reset_abort();
        req = 1'b1; size = 2'b10; iadder = 32'h0000_5000; rs2 = 32'hDEAD_BEEF; resp = 1'b0;
        tick();
        req = 1'b0;
        check_ctl("abort_busy1", 1'b1, 1'b1, 1'b0, 2'b00, 4'b1111);
        tick();
        #3 rst = 1'b1;
        #1;
        check_ctl("abort_async", 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000);
        req = 1'b1; size = 2'b00; iadder = 32'h0000_6001; rs2 = 32'h0000_00A5;
        tick();
        check_ctl("abort_no_pulse", 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000);
        rst = 1'b0;
        #1;
        check_ctl("abort_release", 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000);
        do_store("after_abort", 2'b00, 32'h0000_6001, 32'h0000_00A5, 2);
    endtask

    task automatic test_random();
        logic [1:0]  sz;
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_store($sformatf("rand%0d", n), sz, a, $urandom, int'($urandom_range(1, TO + 1)));
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_resp_in_idle();
        test_reset_abort();
        test_random();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
